host_buffer_bridge: RTL

Host-side counterpart to the BRAM-to-BRAM user application on the Zedboard fabric. It takes a frame of DEPTH 32-bit words from an input valid/ready stream and writes them into the input BRAM. It then drops the `wr_wren`/`rd_rden` hold flags for a fixed copy window so the user application can move the data, and finally drains the output BRAM onto an output valid/ready stream. It owns the host ports of both BRAMs and both hold flags the user application samples.

---
 rtl/host_buffer_bridge.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/host_buffer_bridge.sv
`default_nettype none
// ============================================================================
// Module   : host_buffer_bridge
// Purpose  : Fills the input BRAM from a stream, releases the user app for a
//            fixed copy window, then drains the output BRAM onto a stream.
// Revision : 1.0  initial release
// ============================================================================
module host_buffer_bridge #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 9,
    parameter int DEPTH       = 512,
    parameter int COPY_CYCLES = 514
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH-1:0] in_addr,
    output logic [DATA_WIDTH-1:0] in_wdata,
    output logic [3:0]            in_we,
    output logic                  in_en,
    output logic [ADDR_WIDTH-1:0] out_addr,
    input  logic [DATA_WIDTH-1:0] out_rdata,
    output logic                  out_en,
    output logic                  wr_wren,
    output logic                  rd_rden,
    output logic                  frame_done
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int CP_W  = $clog2(COPY_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_DEPTH     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_LAST      = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
    localparam logic [CP_W-1:0]  C_COPY_LAST = CP_W'(COPY_CYCLES - 1);
    localparam logic [CP_W-1:0]  C_CP_ONE    = CP_W'(1);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_COPY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                state_q;
    logic                  armed_q;
    logic [CNT_W-1:0]      fill_cnt_q;
    logic [CP_W-1:0]       copy_cnt_q;
    logic [CNT_W-1:0]      rd_cnt_q;
    logic [CNT_W-1:0]      pop_cnt_q;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;
    logic [1:0]            fifo_cnt_q;
    logic [ADDR_WIDTH-1:0] in_addr_q;
    logic [DATA_WIDTH-1:0] in_wdata_q;
    logic [3:0]            in_we_q;
    logic                  in_en_q;
    logic                  wr_wren_q;
    logic                  rd_rden_q;

    logic accept_d;
    logic push_d;
    logic pop_d;
    logic issue_d;
    logic last_pop_d;

    assign s_ready  = armed_q && (state_q == ST_FILL) && (fill_cnt_q < C_DEPTH);
    assign accept_d = s_valid && s_ready;
    assign m_valid  = (fifo_cnt_q != 2'd0);
    assign m_data   = fifo_q[rd_ptr_q];
    assign pop_d    = m_valid && m_ready;
    // Read data lands one cycle after issue, so an in-flight read is a push now.
    assign push_d   = inflight_q;
    // Never let buffered + in-flight words exceed the two FIFO slots.
    assign issue_d  = (state_q == ST_DRAIN) && (rd_cnt_q < C_DEPTH) &&
                      (({1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop_d}) < 3'd2);
    assign last_pop_d = (state_q == ST_DRAIN) && pop_d && (pop_cnt_q == C_LAST);

    assign out_en     = issue_d;
    assign out_addr   = issue_d ? rd_cnt_q[ADDR_WIDTH-1:0] : '0;
    assign frame_done = last_pop_d;
    assign in_addr    = in_addr_q;
    assign in_wdata   = in_wdata_q;
    assign in_we      = in_we_q;
    assign in_en      = in_en_q;
    assign wr_wren    = wr_wren_q;
    assign rd_rden    = rd_rden_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_FILL;
            armed_q    <= 1'b0;
            fill_cnt_q <= '0;
            copy_cnt_q <= '0;
            rd_cnt_q   <= '0;
            pop_cnt_q  <= '0;
            inflight_q <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            fifo_cnt_q <= '0;
            in_addr_q  <= '0;
            in_wdata_q <= '0;
            in_we_q    <= '0;
            in_en_q    <= 1'b0;
            wr_wren_q  <= 1'b1;
            rd_rden_q  <= 1'b0;
        end else begin
            armed_q    <= 1'b1;
            in_we_q    <= '0;
            in_en_q    <= 1'b0;
            inflight_q <= issue_d;
            if (issue_d) begin
                rd_cnt_q <= rd_cnt_q + C_CNT_ONE;
            end
            if (push_d) begin
                fifo_q[wr_ptr_q] <= out_rdata;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop_d) begin
                rd_ptr_q  <= ~rd_ptr_q;
                pop_cnt_q <= pop_cnt_q + C_CNT_ONE;
            end
            fifo_cnt_q <= fifo_cnt_q + {1'b0, push_d} - {1'b0, pop_d};

            case (state_q)
                ST_FILL: begin
                    if (accept_d) begin
                        in_addr_q  <= fill_cnt_q[ADDR_WIDTH-1:0];
                        in_wdata_q <= s_data;
                        in_we_q    <= 4'hF;
                        in_en_q    <= 1'b1;
                        fill_cnt_q <= fill_cnt_q + C_CNT_ONE;
                    end else if (fill_cnt_q == C_DEPTH) begin
                        // The final BRAM write is on the port this cycle.
                        state_q    <= ST_COPY;
                        wr_wren_q  <= 1'b0;
                        copy_cnt_q <= '0;
                    end
                end
                ST_COPY: begin
                    copy_cnt_q <= copy_cnt_q + C_CP_ONE;
                    if (copy_cnt_q == C_COPY_LAST) begin
                        state_q   <= ST_DRAIN;
                        rd_rden_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (last_pop_d) begin
                        state_q    <= ST_FILL;
                        wr_wren_q  <= 1'b1;
                        rd_rden_q  <= 1'b0;
                        fill_cnt_q <= '0;
                        copy_cnt_q <= '0;
                        rd_cnt_q   <= '0;
                        pop_cnt_q  <= '0;
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

endmodule
`default_nettype wire
